ws2812_rx: RTL and testbench

- One-wire WS2812/NeoPixel receiver (decoder); the opposite end of the team's `neopixel` one-wire transmitter.
- Samples a one-wire line and measures high-pulse widths to recover bits.
- Assembles bits into 24-bit colour words and detects the latch (reset-low) gap that ends a frame.
- Used for loopback self-test of the NEOPXL pin on the TinyFPGA BX board, and for snooping pixel chains.

---
 rtl/ws2812_rx.sv | 179 +++++++++++++++++
 tb/tb_ws2812_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// ws2812_rx: one-wire WS2812/NeoPixel decoder.
// Measures the synchronised line's high-pulse widths, turns them into bits,
// packs 24-bit GRB words, and reports the latch gap that ends a frame.
module ws2812_rx #(
  parameter int MIN_HIGH   = 2,
  parameter int BIT_THRESH = 10,
  parameter int MAX_HIGH   = 24,
  parameter int RESET_LOW  = 800
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        one_wire,
  output logic [23:0] color,
  output logic        color_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [7:0]  frame_pixels,
  output logic        err_glitch,
  output logic        err_stuck,
  output logic        err_partial
);

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH} state_t;

  localparam logic [16:0] MIN_W    = 17'(MIN_HIGH);
  localparam logic [16:0] THRESH_W = 17'(BIT_THRESH);
  localparam logic [16:0] MAX_W    = 17'(MAX_HIGH);
  localparam logic [16:0] GAP_W    = 17'(RESET_LOW);

  logic        sync1, sync2, line_q;
  logic        edge_seen, rise, fall;
  logic [15:0] wcnt;
  logic [16:0] held;     // cycles the current level has been held, this cycle included
  logic [16:0] width;    // completed high width, meaningful on a falling edge

  state_t      state_q, state_d;
  logic [23:0] shift_q, shift_d;
  logic [4:0]  bits_q, bits_d;
  logic [7:0]  pix_q, pix_d;
  logic [23:0] color_d;
  logic [7:0]  pidx_d, fpix_d;
  logic        cv_d, fd_d, eg_d, es_d, ep_d;
  logic        bit_val;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      line_q <= 1'b0;
    end else begin
      sync1  <= one_wire;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  assign edge_seen = sync2 ^ line_q;
  assign rise      = sync2 & ~line_q;
  assign fall      = ~sync2 & line_q;

  // Saturating width counter; restarts on each edge, where the edge cycle is
  // already the first cycle of the new level.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)           wcnt <= '0;
    else if (edge_seen)     wcnt <= 16'd1;
    else if (wcnt != '1)    wcnt <= wcnt + 16'd1;
  end

  assign held    = edge_seen ? 17'd1 : ({1'b0, wcnt} + 17'd1);
  assign width   = {1'b0, wcnt};
  assign bit_val = (width >= THRESH_W);

  // Decoder next-state and registered-output logic.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    pix_d   = pix_q;
    color_d = color;
    pidx_d  = pixel_index;
    fpix_d  = frame_pixels;
    cv_d    = 1'b0;
    fd_d    = 1'b0;
    eg_d    = 1'b0;
    es_d    = 1'b0;
    ep_d    = 1'b0;
    case (state_q)
      WAIT_GAP: begin
        // Only a full latch gap proves we are at a word boundary.
        if (!sync2 && held >= GAP_W) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
        end else if (held == GAP_W) begin
          // Equality fires once; the saturated counter never matches again.
          if (bits_q != 5'd0) begin
            ep_d    = 1'b1;
            shift_d = '0;
            bits_d  = '0;
            pix_d   = '0;
          end else if (pix_q != 8'd0) begin
            fd_d   = 1'b1;
            fpix_d = pix_q;
            pix_d  = '0;
          end
        end
      end
      HIGH: begin
        if (fall) begin
          if (width < MIN_W) begin
            eg_d    = 1'b1;
            shift_d = '0;
            bits_d  = '0;
            pix_d   = '0;
            state_d = WAIT_GAP;
          end else begin
            state_d = IDLE;
            if (bits_q == 5'd23) begin
              color_d = {shift_q[22:0], bit_val};
              cv_d    = 1'b1;
              pidx_d  = pix_q;
              pix_d   = pix_q + 8'd1;   // wraps 255 -> 0 by design
              shift_d = '0;
              bits_d  = '0;
            end else begin
              shift_d = {shift_q[22:0], bit_val};
              bits_d  = bits_q + 5'd1;
            end
          end
        end else if (held >= MAX_W) begin
          es_d    = 1'b1;
          shift_d = '0;
          bits_d  = '0;
          pix_d   = '0;
          state_d = WAIT_GAP;
        end
      end
      default: state_d = WAIT_GAP;
    endcase
  end

  // Decoder state and output registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_GAP;
      shift_q      <= '0;
      bits_q       <= '0;
      pix_q        <= '0;
      color        <= '0;
      pixel_index  <= '0;
      frame_pixels <= '0;
      color_valid  <= 1'b0;
      frame_done   <= 1'b0;
      err_glitch   <= 1'b0;
      err_stuck    <= 1'b0;
      err_partial  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bits_q       <= bits_d;
      pix_q        <= pix_d;
      color        <= color_d;
      pixel_index  <= pidx_d;
      frame_pixels <= fpix_d;
      color_valid  <= cv_d;
      frame_done   <= fd_d;
      err_glitch   <= eg_d;
      err_stuck    <= es_d;
      err_partial  <= ep_d;
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed self-checking bench for ws2812_rx.
module tb_ws2812_rx;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        one_wire;
  logic [23:0] color;
  logic        color_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_pixels;
  logic        err_glitch, err_stuck, err_partial;

  int errors = 0;
  int checks = 0;

  // Pulse monitor (sampled on the falling clock edge).
  int n_cv = 0, n_fd = 0, n_gl = 0, n_st = 0, n_pa = 0, n_multi = 0;
  logic [23:0] q_color[$];
  logic [7:0]  q_idx[$];
  logic [7:0]  last_fp = '0;

  // Baselines for per-test deltas.
  int b_cv, b_fd, b_gl, b_st, b_pa;

  ws2812_rx dut (
    .CLK(CLK), .reset_n(reset_n), .one_wire(one_wire),
    .color(color), .color_valid(color_valid), .pixel_index(pixel_index),
    .frame_done(frame_done), .frame_pixels(frame_pixels),
    .err_glitch(err_glitch), .err_stuck(err_stuck), .err_partial(err_partial)
  );

  always #5 CLK = ~CLK;

  // Record every pulse; flag cycles with more than one pulse.
  always @(negedge CLK) begin
    if (color_valid) begin
      n_cv++;
      q_color.push_back(color);
      q_idx.push_back(pixel_index);
    end
    if (frame_done) begin
      n_fd++;
      last_fp = frame_pixels;
    end
    if (err_glitch)  n_gl++;
    if (err_stuck)   n_st++;
    if (err_partial) n_pa++;
    if ((int'(color_valid) + int'(frame_done) + int'(err_glitch) +
         int'(err_stuck) + int'(err_partial)) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_cv = n_cv; b_fd = n_fd; b_gl = n_gl; b_st = n_st; b_pa = n_pa;
  endtask

  // Line drivers: each level change is applied on a falling clock edge.
  task automatic drive_high(input int n);
    one_wire = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_low(input int n);
    one_wire = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin drive_high(13); drive_low(7);  end
    else   begin drive_high(6);  drive_low(14); end
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  // Word whose last bit checks the fall-to-color_valid latency.
  task automatic send_word_lat(input logic [23:0] w, input string tag);
    for (int i = 23; i >= 1; i--) send_bit(w[i]);
    drive_high(w[0] ? 13 : 6);
    one_wire = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    check({tag, "_lat_early"}, 32'(color_valid), 32'd0);
    @(posedge CLK); #1;
    check({tag, "_lat_cv"}, 32'(color_valid), 32'd1);
    check({tag, "_lat_color"}, 32'(color), 32'(w));
    @(negedge CLK);
    repeat ((w[0] ? 7 : 14) - 3) @(negedge CLK);
  endtask

  task automatic check_errs_none(input string tag);
    check({tag, "_glitch"},  32'(n_gl - b_gl), 32'd0);
    check({tag, "_stuck"},   32'(n_st - b_st), 32'd0);
    check({tag, "_partial"}, 32'(n_pa - b_pa), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    one_wire = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state.
    check("rst_color",   32'(color),        32'd0);
    check("rst_cv",      32'(color_valid),  32'd0);
    check("rst_idx",     32'(pixel_index),  32'd0);
    check("rst_fd",      32'(frame_done),   32'd0);
    check("rst_fp",      32'(frame_pixels), 32'd0);
    check("rst_errs",    32'({err_glitch, err_stuck, err_partial}), 32'd0);
    reset_n = 1'b1;

    // Single word 0x00FF00 after the initial gap.
    drive_low(810);
    snap();
    send_word(24'h00FF00);
    drive_low(850);
    check("t1_cv_cnt", 32'(n_cv - b_cv), 32'd1);
    check("t1_color",  32'(q_color[b_cv]), 32'h00FF00);
    check("t1_idx",    32'(q_idx[b_cv]),   32'd0);
    check("t1_fd_cnt", 32'(n_fd - b_fd),   32'd1);
    check("t1_fp",     32'(last_fp),       32'd1);
    check_errs_none("t1");

    // Three back-to-back words with latency checks.
    snap();
    send_word_lat(24'h123456, "t2w0");
    send_word_lat(24'hABCDEF, "t2w1");
    send_word_lat(24'h000001, "t2w2");
    drive_low(850);
    check("t2_cv_cnt", 32'(n_cv - b_cv), 32'd3);
    check("t2_c0", 32'(q_color[b_cv]),   32'h123456);
    check("t2_c1", 32'(q_color[b_cv+1]), 32'hABCDEF);
    check("t2_c2", 32'(q_color[b_cv+2]), 32'h000001);
    check("t2_i0", 32'(q_idx[b_cv]),   32'd0);
    check("t2_i1", 32'(q_idx[b_cv+1]), 32'd1);
    check("t2_i2", 32'(q_idx[b_cv+2]), 32'd2);
    check("t2_fd_cnt", 32'(n_fd - b_fd), 32'd1);
    check("t2_fp",     32'(last_fp),     32'd3);
    check("t2_fp_hold", 32'(frame_pixels), 32'd3);
    check_errs_none("t2");

    // Threshold boundary: 9-cycle highs decode 0, 10-cycle highs decode 1.
    snap();
    for (int i = 0; i < 24; i++) begin
      drive_high((i % 2 == 0) ? 9 : 10);
      drive_low(10);
    end
    drive_low(850);
    check("t3_cv_cnt", 32'(n_cv - b_cv),   32'd1);
    check("t3_color",  32'(q_color[b_cv]), 32'h555555);
    check("t3_fp",     32'(last_fp),       32'd1);

    // Glitch: nothing decodes until a full gap has passed.
    snap();
    drive_high(1);
    drive_low(20);
    send_word(24'hFFFFFF);
    drive_low(850);
    check("t4_glitch",   32'(n_gl - b_gl), 32'd1);
    check("t4_no_cv",    32'(n_cv - b_cv), 32'd0);
    check("t4_no_fd",    32'(n_fd - b_fd), 32'd0);
    snap();
    send_word(24'h0F0F0F);
    drive_low(850);
    check("t4_rec_color", 32'(q_color[b_cv]), 32'h0F0F0F);
    check("t4_rec_idx",   32'(q_idx[b_cv]),   32'd0);

    // Stuck high for 24 cycles, then a clean frame.
    snap();
    drive_high(24);
    drive_low(850);
    check("t5_stuck",  32'(n_st - b_st), 32'd1);
    check("t5_no_cv",  32'(n_cv - b_cv), 32'd0);
    snap();
    send_word(24'hA5A5A5);
    drive_low(850);
    check("t5_color",  32'(q_color[b_cv]), 32'hA5A5A5);
    check("t5_idx",    32'(q_idx[b_cv]),   32'd0);
    check("t5_fp",     32'(last_fp),       32'd1);
    check_errs_none("t5");

    // Partial word of 10 bits followed by a gap.
    snap();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    drive_low(850);
    check("t6_partial", 32'(n_pa - b_pa), 32'd1);
    check("t6_no_cv",   32'(n_cv - b_cv), 32'd0);
    check("t6_no_fd",   32'(n_fd - b_fd), 32'd0);
    snap();
    send_word(24'h3C3C3C);
    check("t6_color", 32'(q_color[b_cv]), 32'h3C3C3C);
    check("t6_idx",   32'(q_idx[b_cv]),   32'd0);

    // Reset mid-word (pixel count is 1 here), then one word.
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    snap();
    reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("t7_rst_color", 32'(color),        32'd0);
    check("t7_rst_idx",   32'(pixel_index),  32'd0);
    check("t7_rst_fp",    32'(frame_pixels), 32'd0);
    check("t7_rst_pulses", 32'({color_valid, frame_done, err_glitch, err_stuck, err_partial}), 32'd0);
    reset_n = 1'b1;
    drive_low(850);
    send_word(24'hF0F0F0);
    drive_low(850);
    check("t7_cv_cnt", 32'(n_cv - b_cv),   32'd1);
    check("t7_color",  32'(q_color[b_cv]), 32'hF0F0F0);
    check("t7_idx",    32'(q_idx[b_cv]),   32'd0);
    check("t7_fp",     32'(last_fp),       32'd1);
    check_errs_none("t7");

    check("one_pulse_per_cycle", 32'(n_multi), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
